io_input_conditioner: RTL and testbench

Board-side input stage that sits directly upstream of the pipeline top. It conditions raw DE-board keys and slide switches before they reach the memory-stage IO map (io_button_i, io_sw_i). Each input bit passes through a multi-flop synchronizer and a per-bit counter debouncer. Each button also produces a one-cycle press pulse that software or future interrupt logic can use.

---
 rtl/io_input_conditioner.sv | 82 ++++++++
 tb/tb_io_input_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// Board input conditioner: synchronizes and debounces raw keys and slide
// switches, and emits a one-cycle pulse on every accepted button press.
module io_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
    parameter int unsigned N_BUTTON          = 32,
    parameter int unsigned N_SW              = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_BUTTON-1:0] raw_button_i,
    input  logic [N_SW-1:0]     raw_sw_i,
    output logic [N_BUTTON-1:0] io_button_o,
    output logic [N_SW-1:0]     io_sw_o,
    output logic [N_BUTTON-1:0] button_press_o
);

    // Buttons occupy the low channel bits, switches the high bits.
    localparam int unsigned N_CH  = N_BUTTON + N_SW;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTON-1:0]                 button_in;
    logic [N_CH-1:0]                     chan_in;
    logic [SYNC_STAGES-1:0][N_CH-1:0]    sync_q;
    logic [N_CH-1:0]                     synced;
    logic [N_CH-1:0][CNT_W-1:0]          cnt_q;
    logic [N_CH-1:0][CNT_W-1:0]          cnt_d;
    logic [N_CH-1:0]                     level_q;
    logic [N_CH-1:0]                     level_d;
    logic [N_BUTTON-1:0]                 press_q;

    // Normalize keys to active-high so a cleared synchronizer means "released".
    assign button_in = BUTTON_ACTIVE_LOW ? ~raw_button_i : raw_button_i;
    assign chan_in   = {raw_sw_i, button_in};
    assign synced    = sync_q[SYNC_STAGES-1];

    // Multi-flop synchronizer, stage 0 samples the pins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], chan_in};
        end
    end

    // Per-bit debounce: any matching cycle clears the count, a full run of
    // mismatching cycles accepts the new level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (synced[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = synced[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state, counters and press pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= '0;
            press_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= level_d[N_BUTTON-1:0] & ~level_q[N_BUTTON-1:0];
        end
    end

    assign io_button_o    = level_q[N_BUTTON-1:0];
    assign io_sw_o        = level_q[N_CH-1:N_BUTTON];
    assign button_press_o = press_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with small debounce depth; expected
// output snapshots are queued per cycle and compared on the falling edge.
module tb_io_input_conditioner;

    logic        clk;
    logic        rst_ni;
    logic [31:0] raw_button;
    logic [31:0] raw_sw;
    logic [31:0] io_button;
    logic [31:0] io_sw;
    logic [31:0] press;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] b;
        logic [31:0] s;
        logic [31:0] p;
    } exp_t;

    exp_t sb[$];

    io_input_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .SYNC_STAGES      (2),
        .BUTTON_ACTIVE_LOW(1'b1),
        .N_BUTTON         (32),
        .N_SW             (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .raw_button_i  (raw_button),
        .raw_sw_i      (raw_sw),
        .io_button_o   (io_button),
        .io_sw_o       (io_sw),
        .button_press_o(press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: value seen at a falling edge = number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] eb,
                       input logic [31:0] es, input logic [31:0] ep);
        checks++;
        assert ({io_button, io_sw, press} === {eb, es, ep}) else begin
            errors++;
            $error("FAIL %s cyc=%0d btn=%h/%h sw=%h/%h press=%h/%h (got/exp)",
                   tag, cyc, io_button, eb, io_sw, es, press, ep);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [31:0] b,
                        input logic [31:0] s, input logic [31:0] p);
        exp_t e;
        e.cyc = at;
        e.tag = tag;
        e.b   = b;
        e.s   = s;
        e.p   = p;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: compare every entry due at this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, e.b, e.s, e.p);
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int t;
        rst_ni     = 1'b0;
        raw_button = 32'hFFFF_FFFE;
        raw_sw     = 32'h0000_00A5;

        // Reset with a key held and switches set: outputs stay cleared.
        repeat (2) begin
            @(negedge clk);
            #1 chk("in_reset", 32'h0, 32'h0, 32'h0);
        end

        // Release: held key and switches accepted after normal latency, one pulse.
        @(negedge clk);
        rst_ni = 1'b1;
        t = cyc;
        push(t + 5, "rst_latency", 32'h0, 32'h0,  32'h0);
        push(t + 6, "rst_accept",  32'h1, 32'hA5, 32'h1);
        push(t + 7, "rst_pulse1",  32'h1, 32'hA5, 32'h0);
        wait_drain();

        // Let key 0 go.
        @(negedge clk);
        raw_button = 32'hFFFF_FFFF;
        t = cyc;
        push(t + 5, "rel0_hold", 32'h1, 32'hA5, 32'h0);
        push(t + 6, "rel0_done", 32'h0, 32'hA5, 32'h0);
        wait_drain();

        // Clean press then release of key 0.
        @(negedge clk);
        raw_button = 32'hFFFF_FFFE;
        t = cyc;
        push(t + 5, "press_latency", 32'h0, 32'hA5, 32'h0);
        push(t + 6, "press_accept",  32'h1, 32'hA5, 32'h1);
        push(t + 7, "press_pulse1",  32'h1, 32'hA5, 32'h0);
        wait_drain();
        repeat (10) @(negedge clk);
        raw_button = 32'hFFFF_FFFF;
        t = cyc;
        push(t + 5, "release_latency", 32'h1, 32'hA5, 32'h0);
        push(t + 6, "release_nopulse", 32'h0, 32'hA5, 32'h0);
        push(t + 7, "release_stable",  32'h0, 32'hA5, 32'h0);
        wait_drain();

        // Glitch: key 1 low for only three cycles is never accepted.
        @(negedge clk);
        raw_button = 32'hFFFF_FFFD;
        t = cyc;
        for (int k = 1; k <= 9; k++) push(t + k, "glitch", 32'h0, 32'hA5, 32'h0);
        repeat (3) @(negedge clk);
        raw_button = 32'hFFFF_FFFF;
        wait_drain();

        // Bounce on key 2, then held pressed: single accept and single pulse.
        @(negedge clk);
        t = cyc;
        for (int k = 1; k <= 17; k++) push(t + k, "bounce_quiet", 32'h0, 32'hA5, 32'h0);
        push(t + 18, "bounce_accept", 32'h4, 32'hA5, 32'h4);
        push(t + 19, "bounce_pulse1", 32'h4, 32'hA5, 32'h0);
        push(t + 22, "bounce_stable", 32'h4, 32'hA5, 32'h0);
        for (int ph = 0; ph < 6; ph++) begin
            raw_button = (ph % 2 == 0) ? 32'hFFFF_FFFB : 32'hFFFF_FFFF;
            repeat (2) @(negedge clk);
        end
        raw_button = 32'hFFFF_FFFB;
        wait_drain();
        @(negedge clk);
        raw_button = 32'hFFFF_FFFF;
        t = cyc;
        push(t + 5, "rel2_hold", 32'h4, 32'hA5, 32'h0);
        push(t + 6, "rel2_done", 32'h0, 32'hA5, 32'h0);
        wait_drain();

        // Parallel channels: switches and key 3 change on the same edge.
        @(negedge clk);
        raw_sw = 32'h0;
        t = cyc;
        push(t + 5, "sw_clr_hold", 32'h0, 32'hA5, 32'h0);
        push(t + 6, "sw_clr_done", 32'h0, 32'h0,  32'h0);
        wait_drain();
        @(negedge clk);
        raw_sw     = 32'hFF;
        raw_button = 32'hFFFF_FFF7;
        t = cyc;
        push(t + 5, "par_latency", 32'h0, 32'h0,  32'h0);
        push(t + 6, "par_accept",  32'h8, 32'hFF, 32'h8);
        push(t + 7, "par_pulse1",  32'h8, 32'hFF, 32'h0);
        wait_drain();

        // Reset in the middle of a pending count on key 0.
        @(negedge clk);
        raw_button = 32'hFFFF_FFFE;
        t = cyc;
        push(t + 4, "pre_reset", 32'h8, 32'hFF, 32'h0);
        repeat (4) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1 chk("async_reset", 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1 chk("mid_reset_hold", 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        t = cyc;
        push(t + 5, "post_rst_latency", 32'h0, 32'h0,  32'h0);
        push(t + 6, "post_rst_accept",  32'h1, 32'hFF, 32'h1);
        push(t + 7, "post_rst_pulse1",  32'h1, 32'hFF, 32'h0);
        push(t + 8, "post_rst_stable",  32'h1, 32'hFF, 32'h0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
